// File: rtl/fft_addr_sequencer.sv
// Radix-2 DIT butterfly address/twiddle sequencer; first issue 1 cycle after start, stall freezes progress.
// Optional stall counter under FFT_ADDR_SEQ_STALL_CNT_EN; otherwise stallCycles is tied to 0.
module fft_addr_sequencer #(
  parameter int N_LOG2 = 10,
  parameter int BF_LAT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       isIFFT,
  input  logic                       abort,
  input  logic                       stall,
  output logic                       issueValid,
  output logic [N_LOG2-1:0]          addrA,
  output logic [N_LOG2-1:0]          addrB,
  output logic [N_LOG2-2:0]          twiddleIdx,
  output logic                       conjTwiddle,
  output logic [$clog2(N_LOG2+1)-1:0] stageNum,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                stallCycles
);
  localparam int SW = $clog2(N_LOG2 + 1);
  localparam int KW = N_LOG2 - 1;
  localparam int CW = $clog2(BF_LAT + 1);
  localparam logic [KW-1:0] K_LAST = {KW{1'b1}};
  localparam logic [SW-1:0] S_LAST = SW'(N_LOG2 - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t        state, stateNext;
  logic [KW-1:0] k, kNext, ldK;
  logic [SW-1:0] s, sNext, ldS;
  logic [CW-1:0] cnt, cntNext;
  logic          conjNext, loadAddr;

  function automatic logic [N_LOG2-1:0] posOf(input logic [SW-1:0] st, input logic [KW-1:0] kk);
    return {1'b0, kk} & ((N_LOG2'(1) << st) - N_LOG2'(1));
  endfunction

  function automatic logic [N_LOG2-1:0] calcA(input logic [SW-1:0] st, input logic [KW-1:0] kk);
    logic [N_LOG2-1:0] grp;
    grp = {1'b0, kk} >> st;
    return (grp << (st + SW'(1))) | posOf(st, kk);
  endfunction

  function automatic logic [KW-1:0] calcTw(input logic [SW-1:0] st, input logic [KW-1:0] kk);
    logic [N_LOG2-1:0] p;
    p = posOf(st, kk);
    return p[KW-1:0] << (S_LAST - st);
  endfunction

  always_comb begin
    stateNext = state;
    kNext     = k;
    sNext     = s;
    cntNext   = cnt;
    conjNext  = conjTwiddle;
    loadAddr  = 1'b0;
    ldS       = s;
    ldK       = k;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext = ISSUE;
          kNext     = '0;
          sNext     = '0;
          conjNext  = isIFFT;
          loadAddr  = 1'b1;
          ldS       = '0;
          ldK       = '0;
        end
      end
      ISSUE: begin
        if (!stall) begin
          if (k == K_LAST) begin
            kNext     = '0;
            cntNext   = CW'(BF_LAT);
            stateNext = DRAIN;
          end else begin
            kNext    = k + KW'(1);
            loadAddr = 1'b1;
            ldK      = k + KW'(1);
          end
        end
      end
      DRAIN: begin
        // Wait out the butterfly latency so the next stage reads written-back data.
        if (!stall) begin
          if (cnt == CW'(1)) begin
            if (s == S_LAST) begin
              stateNext = DONE;
            end else begin
              sNext     = s + SW'(1);
              stateNext = ISSUE;
              loadAddr  = 1'b1;
              ldS       = s + SW'(1);
              ldK       = '0;
            end
          end else begin
            cntNext = cnt - CW'(1);
          end
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (abort && state != IDLE) begin
      stateNext = IDLE;
      kNext     = k;
      sNext     = s;
      cntNext   = cnt;
      loadAddr  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      s           <= '0;
      cnt         <= '0;
      conjTwiddle <= 1'b0;
      addrA       <= '0;
      addrB       <= '0;
      twiddleIdx  <= '0;
    end else begin
      state       <= stateNext;
      k           <= kNext;
      s           <= sNext;
      cnt         <= cntNext;
      conjTwiddle <= conjNext;
      // Addresses are precomputed for the next butterfly, so they hold across stalls.
      if (loadAddr) begin
        addrA      <= calcA(ldS, ldK);
        addrB      <= calcA(ldS, ldK) + (N_LOG2'(1) << ldS);
        twiddleIdx <= calcTw(ldS, ldK);
      end
    end
  end

  assign issueValid = (state == ISSUE) && !stall && !abort;
  assign done       = (state == DONE) && !abort;
  assign busy       = (state != IDLE);
  assign stageNum   = s;

`ifdef FFT_ADDR_SEQ_STALL_CNT_EN
  logic [15:0] stallCnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (state == IDLE && start) begin
      stallCnt <= '0;
    end else if (busy && stall && stallCnt != 16'hFFFF) begin
      stallCnt <= stallCnt + 16'd1;
    end
  end
  assign stallCycles = stallCnt;
`else
  assign stallCycles = 16'd0;
`endif

endmodule

// File: tb/tb_fft_addr_sequencer.sv
// Directed bench: a small instance (N_LOG2=3, BF_LAT=2) for sequencing/stall/abort, defaults for pass timing.
module tb_fft_addr_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic sStart, sIfft, sAbort, sStall, sValid, sConj, sBusy, sDone;
  logic [2:0] sA, sB;
  logic [1:0] sTw, sStage;
  logic [15:0] sStallCyc;

  logic bStart, bIfft, bAbort, bStall, bValid, bConj, bBusy, bDone;
  logic [9:0] bA, bB;
  logic [8:0] bTw;
  logic [3:0] bStage;
  logic [15:0] bStallCyc;

  fft_addr_sequencer #(.N_LOG2(3), .BF_LAT(2)) uSmall (
    .clk(clk), .rst(rst), .start(sStart), .isIFFT(sIfft), .abort(sAbort), .stall(sStall),
    .issueValid(sValid), .addrA(sA), .addrB(sB), .twiddleIdx(sTw), .conjTwiddle(sConj),
    .stageNum(sStage), .busy(sBusy), .done(sDone), .stallCycles(sStallCyc));

  fft_addr_sequencer uBig (
    .clk(clk), .rst(rst), .start(bStart), .isIFFT(bIfft), .abort(bAbort), .stall(bStall),
    .issueValid(bValid), .addrA(bA), .addrB(bB), .twiddleIdx(bTw), .conjTwiddle(bConj),
    .stageNum(bStage), .busy(bBusy), .done(bDone), .stallCycles(bStallCyc));

  int nChecks = 0;
  int nFails = 0;
  logic [9:0] iss[16];
  logic [9:0] expTab[12];
  int nIss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start a small pass and run up to 40 cycles; doneAt is the cycle of done relative to start, -1 if none.
  task automatic runSmall(input bit stl, input bit pulses, input int abortAt, output int doneAt);
    sIfft = 1'b0; sStart = 1'b1;
    step();
    sStart = 1'b0;
    nIss = 0;
    doneAt = -1;
    for (int c = 1; c <= 40; c++) begin
      sStall = stl && ((c >= 2 && c <= 6) || (c >= 10 && c <= 14));
      sStart = pulses && (c == 5 || c == 12);
      sIfft  = sStart;
      sAbort = (c == abortAt);
      #1;
      if (sStall && c <= 6) begin
        check("stallIssueValid", 32'(sValid), 32'd0);
        check("stallAddrHold", 32'(sA), 32'd2);
      end
      if (sStall && c >= 10) check("stallDrainValid", 32'(sValid), 32'd0);
      if (abortAt > 0 && c == abortAt + 1) check("abortBusy", 32'(sBusy), 32'd0);
      if (sValid && nIss < 16) begin
        iss[nIss] = {sStage, sA, sB, sTw};
        nIss++;
      end
      if (sDone) begin
        doneAt = c;
        break;
      end
      step();
    end
    sStall = 1'b0; sStart = 1'b0; sIfft = 1'b0; sAbort = 1'b0;
  endtask

  initial begin
    int d;
    int conjBad;
    logic [15:0] expStall;
`ifdef FFT_ADDR_SEQ_STALL_CNT_EN
    expStall = 16'd10;
`else
    expStall = 16'd0;
`endif
    expTab = '{{2'd0,3'd0,3'd1,2'd0}, {2'd0,3'd2,3'd3,2'd0}, {2'd0,3'd4,3'd5,2'd0}, {2'd0,3'd6,3'd7,2'd0},
               {2'd1,3'd0,3'd2,2'd0}, {2'd1,3'd1,3'd3,2'd2}, {2'd1,3'd4,3'd6,2'd0}, {2'd1,3'd5,3'd7,2'd2},
               {2'd2,3'd0,3'd4,2'd0}, {2'd2,3'd1,3'd5,2'd1}, {2'd2,3'd2,3'd6,2'd2}, {2'd2,3'd3,3'd7,2'd3}};
    rst = 1'b1;
    sStart = 0; sIfft = 0; sAbort = 0; sStall = 0;
    bStart = 0; bIfft = 0; bAbort = 0; bStall = 0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("resetSmall", {sValid, sA, sB, sTw, sConj, sStage, sBusy, sDone, sStallCyc}, 32'd0);
    check("resetBig", {bValid, bConj, bBusy, bDone, bA, bB, bTw}, 32'd0);
    check("resetBigMisc", {bStage, bStallCyc}, 32'd0);

    // Plain pass: full address/twiddle sequence and done latency.
    runSmall(1'b0, 1'b0, 0, d);
    check("seqCount", nIss, 32'd12);
    for (int i = 0; i < 12; i++) check($sformatf("seq%0d", i), 32'(iss[i]), 32'(expTab[i]));
    check("doneAt", d, 32'd19);
    step(); #1;
    check("busyAfterDone", 32'(sBusy), 32'd0);

    // Stall 5 cycles in ISSUE and 5 in DRAIN.
    runSmall(1'b1, 1'b0, 0, d);
    check("stallDoneAt", d, 32'd29);
    check("stallSeqCount", nIss, 32'd12);
    check("stallCycles", 32'(sStallCyc), 32'(expStall));
    step();

    // Abort mid-ISSUE in stage 2, then a fresh start begins at stage 0.
    runSmall(1'b0, 1'b0, 14, d);
    check("abortNoDone", d, -1);
    sStart = 1'b1;
    step();
    sStart = 1'b0;
    #1;
    check("restartValid", 32'(sValid), 32'd1);
    check("restartAddrA", 32'(sA), 32'd0);
    check("restartStage", 32'(sStage), 32'd0);
    sAbort = 1'b1;
    step();
    sAbort = 1'b0;

    // Start pulses while busy are ignored.
    runSmall(1'b0, 1'b1, 0, d);
    check("busyStartDoneAt", d, 32'd19);
    check("busyStartConj", 32'(sConj), 32'd0);
    step();

    // Abort coinciding with the DONE state suppresses done.
    runSmall(1'b0, 1'b0, 19, d);
    check("abortDoneNoPulse", d, -1);
    step();

    // Reset during DRAIN clears every output.
    sIfft = 1'b1; sStart = 1'b1;
    step();
    sStart = 1'b0; sIfft = 1'b0;
    step();
    sStall = 1'b1;
    step();
    sStall = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    #1;
    check("preRstBusy", 32'(sBusy), 32'd1);
    check("preRstConj", 32'(sConj), 32'd1);
    step();
    rst = 1'b0;
    #1;
    check("rstOutputs", {sValid, sA, sB, sTw, sConj, sStage, sBusy, sDone, sStallCyc}, 32'd0);

    // Default-size IFFT pass.
    bIfft = 1'b1; bStart = 1'b1;
    step();
    bStart = 1'b0; bIfft = 1'b0;
    d = -1;
    conjBad = 0;
    for (int c = 1; c <= 5300; c++) begin
      #1;
      if (bConj !== 1'b1) conjBad++;
      if (bDone) begin
        d = c;
        break;
      end
      step();
    end
    check("bigDoneAt", d, 32'd5161);
    check("bigConjPass", conjBad, 32'd0);
    check("bigBusyAtDone", 32'(bBusy), 32'd1);
    step(); #1;
    check("bigBusyAfter", 32'(bBusy), 32'd0);
    check("bigConjHold", 32'(bConj), 32'd1);

`ifdef FFT_ADDR_SEQ_STALL_CNT_EN
    sStart = 1'b1;
    step();
    sStart = 1'b0;
    sStall = 1'b1;
    repeat (70000) step();
    #1;
    check("stallSaturate", 32'(sStallCyc), 32'hFFFF);
    sAbort = 1'b1;
    step();
    sAbort = 1'b0; sStall = 1'b0;
    #1;
    check("stallHoldAfterAbort", 32'(sStallCyc), 32'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
